// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and a width helper for the UART transmit path.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CR      = 3'd2,
        ST_LF      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Bits needed to represent values 0..value-1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_msg_tx.sv
// Wide-message serializer: streams up to MAX_BYTES bytes MSB-first, optional CR/LF.
// Latency 1 clock strobe->first valid; holds byte/valid stable while i_byte_ready is low.
module uart_msg_tx
    import uart_pkg::*;
#(
    parameter int MAX_BYTES   = 1000,
    parameter int LEN_W       = 10,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_tx_stb,
    input  logic [8*MAX_BYTES-1:0] i_tx_data,
    input  logic [LEN_W-1:0]       i_tx_len,
    input  logic                   i_abort,
    output logic [7:0]             o_byte,
    output logic                   o_byte_valid,
    input  logic                   i_byte_ready,
    output logic                   o_tx_busy,
    output logic                   o_tx_done,
    output logic [LEN_W-1:0]       o_tx_remaining
);

    localparam int               DW      = 8 * MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    if (MAX_BYTES < 1 || LEN_W < clog2_f(MAX_BYTES + 1)) begin : g_param_chk
        $error("uart_msg_tx: MAX_BYTES must be >= 1 and 2**LEN_W > MAX_BYTES");
    end

    state_e           state_q, state_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] len_clamped;
    logic             xfer;

    assign xfer        = byte_valid_q & i_byte_ready;
    assign len_clamped = (i_tx_len > MAX_LEN) ? MAX_LEN : i_tx_len;

    // shreg holds the bytes still to be presented after o_byte, top-aligned.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;
        remaining_d  = remaining_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_tx_stb) begin
                    shreg_d     = i_tx_data << 8;
                    remaining_d = len_clamped;
                    if (len_clamped != '0) begin
                        state_d      = ST_PAYLOAD;
                        byte_d       = i_tx_data[DW-1 -: 8];
                        byte_valid_d = 1'b1;
                    end else if (APPEND_CRLF) begin
                        state_d      = ST_CR;
                        byte_d       = ASCII_CR;
                        byte_valid_d = 1'b1;
                    end else begin
                        state_d      = ST_DONE;
                        byte_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    shreg_d     = shreg_q << 8;
                    if (remaining_q == LEN_W'(1)) begin
                        if (APPEND_CRLF) begin
                            state_d = ST_CR;
                            byte_d  = ASCII_CR;
                        end else begin
                            state_d      = ST_DONE;
                            byte_valid_d = 1'b0;
                            done_d       = 1'b1;
                        end
                    end else begin
                        byte_d = shreg_q[DW-1 -: 8];
                    end
                end
            end
            ST_CR: begin
                if (xfer) begin
                    state_d = ST_LF;
                    byte_d  = ASCII_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    state_d      = ST_DONE;
                    byte_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                byte_valid_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                byte_valid_d = 1'b0;
            end
        endcase

        // Abort wins over any progress; a byte accepted this cycle still counts as sent.
        if (i_abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            byte_valid_d = 1'b0;
            remaining_d  = '0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            remaining_q  <= remaining_d;
        end
    end

    assign o_byte         = byte_q;
    assign o_byte_valid   = byte_valid_q;
    assign o_tx_busy      = busy_q;
    assign o_tx_done      = done_q;
    assign o_tx_remaining = remaining_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: two instances (with and without CR/LF) against a queue-based model.
module tb_uart_msg_tx;

    localparam int MB = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic [31:0]   data = '0;
    logic [LW-1:0] len = '0;

    logic [7:0]    ob    [2];
    logic          ov    [2];
    logic          obusy [2];
    logic          odone [2];
    logic [LW-1:0] orem  [2];

    always #5 clk = ~clk;

    uart_msg_tx #(.MAX_BYTES(MB), .LEN_W(LW), .APPEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_tx_stb(stb), .i_tx_data(data), .i_tx_len(len),
        .i_abort(abort), .o_byte(ob[0]), .o_byte_valid(ov[0]), .i_byte_ready(ready),
        .o_tx_busy(obusy[0]), .o_tx_done(odone[0]), .o_tx_remaining(orem[0])
    );

    uart_msg_tx #(.MAX_BYTES(MB), .LEN_W(LW), .APPEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_tx_stb(stb), .i_tx_data(data), .i_tx_len(len),
        .i_abort(abort), .o_byte(ob[1]), .o_byte_valid(ov[1]), .i_byte_ready(ready),
        .o_tx_busy(obusy[1]), .o_tx_done(odone[1]), .o_tx_remaining(orem[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: per instance, the list of bytes the message must produce.
    logic [7:0] mbuf [2][8];
    int         mlen [2];
    int         mhead[2];
    int         mpay [2];
    bit         mact [2];
    bit         mdone[2];

    // Observation logs (transfers, done pulses, busy cycles).
    logic [7:0] lg_b  [2][16];
    int         lg_r  [2][16];
    int         lg_n  [2];
    int         done_n[2];
    int         done_c[2];
    int         busy_n[2];
    logic       pv    [2];
    logic [7:0] pb    [2];
    int         prem  [2];

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d at cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mact[d] = 0; mdone[d] = 0; mlen[d] = 0; mhead[d] = 0; mpay[d] = 0;
            lg_n[d] = 0; done_n[d] = 0; done_c[d] = -1; busy_n[d] = 0;
            pv[d] = 1'b0; pb[d] = '0; prem[d] = 0;
        end
    end

    // Inputs change only on negedge, so 1 time unit after posedge they still
    // hold the values the DUT just sampled while the outputs are already updated.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int exp_rem;
            if (pv[d] && ready) begin
                if (lg_n[d] < 16) begin
                    lg_b[d][lg_n[d]] = pb[d];
                    lg_r[d][lg_n[d]] = prem[d];
                end
                lg_n[d]++;
            end
            if (odone[d] === 1'b1) begin
                done_n[d]++;
                done_c[d] = cyc;
            end
            if (obusy[d] === 1'b1) busy_n[d]++;

            if (rst) begin
                mact[d]  = 0;
                mdone[d] = 0;
            end else if (mdone[d]) begin
                mdone[d] = 0;
            end else if (mact[d]) begin
                if (ready) mhead[d]++;
                if (abort) mact[d] = 0;
                else if (mhead[d] == mlen[d]) begin
                    mact[d]  = 0;
                    mdone[d] = 1;
                end
            end else if (stb) begin
                mpay[d] = (int'(len) > MB) ? MB : int'(len);
                mlen[d] = 0;
                for (int k = 0; k < mpay[d]; k++) begin
                    mbuf[d][mlen[d]] = data[31-8*k -: 8];
                    mlen[d]++;
                end
                if (d == 0) begin
                    mbuf[d][mlen[d]] = 8'h0D; mlen[d]++;
                    mbuf[d][mlen[d]] = 8'h0A; mlen[d]++;
                end
                mhead[d] = 0;
                if (mlen[d] > 0) mact[d] = 1;
                else mdone[d] = 1;
            end

            exp_rem = 0;
            if (mact[d] && mpay[d] > mhead[d]) exp_rem = mpay[d] - mhead[d];
            check("busy", d, 32'(obusy[d]), 32'(mact[d] || mdone[d]));
            check("valid", d, 32'(ov[d]), 32'(mact[d]));
            check("done", d, 32'(odone[d]), 32'(mdone[d]));
            check("remaining", d, 32'(orem[d]), 32'(exp_rem));
            if (mact[d]) check("byte", d, 32'(ob[d]), 32'(mbuf[d][mhead[d]]));

            pv[d]   = ov[d];
            pb[d]   = ob[d];
            prem[d] = int'(orem[d]);
        end
    end

    task automatic clr_logs();
        for (int d = 0; d < 2; d++) begin
            lg_n[d] = 0; done_n[d] = 0; done_c[d] = -1; busy_n[d] = 0;
        end
    endtask

    // Called at a negedge; returns the cycle index at which the strobe was sampled.
    task automatic send(input logic [31:0] dt, input logic [LW-1:0] ln, output int c0);
        data = dt;
        len  = ln;
        stb  = 1'b1;
        @(negedge clk);
        c0  = cyc;
        stb = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((obusy[0] || obusy[1]) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 0, 32'(obusy[0] | obusy[1]), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_bytes(input string nm, input int d, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                               input logic [7:0] e5, input int n);
        logic [7:0] e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        check({nm, "_count"}, d, 32'(lg_n[d]), 32'(n));
        for (int k = 0; k < n && k < lg_n[d]; k++) check(nm, d, 32'(lg_b[d][k]), 32'(e[k]));
    endtask

    task automatic check_reset_outputs(input string nm);
        for (int d = 0; d < 2; d++) begin
            check({nm, "_byte"}, d, 32'(ob[d]), 32'd0);
            check({nm, "_valid"}, d, 32'(ov[d]), 32'd0);
            check({nm, "_busy"}, d, 32'(obusy[d]), 32'd0);
            check({nm, "_done"}, d, 32'(odone[d]), 32'd0);
            check({nm, "_rem"}, d, 32'(orem[d]), 32'd0);
        end
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst   = 1'b0;
        ready = 1'b1;
        @(negedge clk);

        // Full 4-byte message, ready held high.
        clr_logs();
        send(32'h41424344, 3'd4, c0);
        wait_idle(40);
        check_bytes("t1_bytes", 0, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A, 6);
        check("t1_done_cyc", 0, 32'(done_c[0]), 32'(c0 + 6));
        check("t1_done_n", 0, 32'(done_n[0]), 32'd1);
        check("t1_busy_n", 0, 32'(busy_n[0]), 32'd7);
        check_bytes("t1_bytes", 1, 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 8'h00, 4);
        check("t1_done_cyc", 1, 32'(done_c[1]), 32'(c0 + 4));

        // Short message: remaining counts 2,1,0.
        clr_logs();
        send(32'h41424344, 3'd2, c0);
        wait_idle(40);
        check_bytes("t2_bytes", 0, 8'h41, 8'h42, 8'h0D, 8'h0A, 8'h00, 8'h00, 4);
        check("t2_rem0", 0, 32'(lg_r[0][0]), 32'd2);
        check("t2_rem1", 0, 32'(lg_r[0][1]), 32'd1);
        check("t2_rem2", 0, 32'(lg_r[0][2]), 32'd0);
        check("t2_done_n", 0, 32'(done_n[0]), 32'd1);

        // Ready toggling every cycle.
        clr_logs();
        send(32'h41424344, 3'd3, c0);
        begin
            int n;
            n = 0;
            while ((obusy[0] || obusy[1]) && n < 60) begin
                ready = ~ready;
                @(negedge clk);
                n++;
            end
        end
        ready = 1'b1;
        wait_idle(10);
        check_bytes("t3_bytes", 0, 8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A, 8'h00, 5);
        check("t3_done_n", 0, 32'(done_n[0]), 32'd1);
        check_bytes("t3_bytes", 1, 8'h41, 8'h42, 8'h43, 8'h00, 8'h00, 8'h00, 3);

        // Zero-length message.
        clr_logs();
        send(32'h41424344, 3'd0, c0);
        wait_idle(20);
        check("t4_b_count", 1, 32'(lg_n[1]), 32'd0);
        check("t4_b_done_cyc", 1, 32'(done_c[1]), 32'(c0));
        check("t4_b_done_n", 1, 32'(done_n[1]), 32'd1);
        check_bytes("t4_bytes", 0, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        check("t4_a_done_cyc", 0, 32'(done_c[0]), 32'(c0 + 2));

        // Length above capacity is clamped.
        clr_logs();
        send(32'h41424344, 3'd7, c0);
        wait_idle(40);
        check_bytes("t5_bytes", 0, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A, 6);
        check("t5_b_count", 1, 32'(lg_n[1]), 32'd4);
        check("t5_b_rem0", 1, 32'(lg_r[1][0]), 32'd4);

        // Abort sampled on the cycle of the 2nd transfer, then an immediate new message.
        clr_logs();
        send(32'h41424344, 3'd4, c0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_busy", 0, 32'(obusy[0]), 32'd0);
        check("t6_valid", 0, 32'(ov[0]), 32'd0);
        check("t6_count", 0, 32'(lg_n[0]), 32'd2);
        check("t6_done_n", 0, 32'(done_n[0]), 32'd0);
        clr_logs();
        send(32'h61626364, 3'd2, c0);
        wait_idle(40);
        check_bytes("t6_new", 0, 8'h61, 8'h62, 8'h0D, 8'h0A, 8'h00, 8'h00, 4);
        check("t6_new_done_n", 0, 32'(done_n[0]), 32'd1);

        // Reset mid-message.
        clr_logs();
        send(32'h41424344, 3'd4, c0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t7_rst");
        rst = 1'b0;
        check("t7_done_n", 0, 32'(done_n[0]), 32'd0);
        @(negedge clk);

        // Second strobe while busy is ignored.
        clr_logs();
        send(32'h41424344, 3'd4, c0);
        @(negedge clk);
        data = 32'h55565758;
        len  = 3'd1;
        stb  = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        wait_idle(40);
        check_bytes("t8_bytes", 0, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A, 6);
        check("t8_done_n", 0, 32'(done_n[0]), 32'd1);
        check("t8_b_count", 1, 32'(lg_n[1]), 32'd4);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
